// File: rtl/imem_loader_pkg.sv
// ----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the boot-time instruction-memory loader:
//   - state_t     : loader FSM states
//   - LEN_BYTES   : number of length-header bytes in a frame
//   - WORD_BYTES  : number of stream bytes per instruction word
//   - xor_fold()  : one step of the 8-bit XOR checksum
// ----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        LEN_LO,
        LEN_HI,
        LOAD,
        CHECK,
        RUN,
        ERROR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Folds one more stream byte into the running checksum.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// ----------------------------------------------------------------------------
// byte_packer
// Assembles little-endian 32-bit words from a byte stream. The first byte of a
// word lands in word_data[7:0]. word_valid is a combinational pulse during the
// cycle in which the 4th byte is presented, so the caller can register the
// completed word on the same edge that accepts that byte.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   clear        : synchronous restart of the byte position
//   byte_valid   : byte_data is consumed on this edge
//   byte_data    : stream byte
//   word_valid   : the presented byte completes a word
//   word_data    : the completed word (valid with word_valid)
// ----------------------------------------------------------------------------
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word_data
);

    logic [1:0]  byte_cnt;
    // Holds the first three bytes of the current word, newest at the top.
    logic [23:0] shreg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= {byte_data, shreg[23:8]};
        end
    end

    assign word_valid = byte_valid && (byte_cnt == 2'(WORD_BYTES - 1));
    assign word_data  = {byte_data, shreg};

endmodule

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
// Boot-time program loader. Receives a frame (16-bit little-endian word count,
// count*4 payload bytes, XOR checksum byte) over a valid/ready byte stream,
// writes each assembled word into instruction memory and releases the core
// from reset only after a good checksum.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   in_valid/in_data     : incoming stream byte
//   in_ready             : loader accepts a byte (registered)
//   reload               : in RUN, restart loading a new frame
//   imem_we/addr/wdata   : registered one-cycle instruction-memory write
//   core_reset           : core reset, high except in RUN
//   done                 : program loaded and core running
//   error                : load failed, sticky until reset
// ----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_reset,
    output logic                  done,
    output logic                  error
);

    localparam int             CW        = 8 * LEN_BYTES;
    localparam logic [CW:0]    MAX_COUNT = (CW + 1)'(2 ** ADDR_WIDTH);

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
    logic [7:0]            xor_q, xor_d;

    logic                  in_ready_d, imem_we_d, core_reset_d, done_d, error_d;
    logic [ADDR_WIDTH-1:0] imem_addr_d;
    logic [31:0]           imem_wdata_d;

    logic                  accept;
    logic                  packer_clear;
    logic                  packer_valid;
    logic                  word_valid;
    logic [31:0]           word_data;
    logic [CW-1:0]         header;

    assign accept       = in_valid && in_ready;
    assign packer_valid = accept && (state_q == LOAD);
    // Length bytes shift in from the top, so after LEN_HI the header is whole.
    assign header       = {in_data, count_q[CW-1:8]};

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (packer_clear),
        .byte_valid (packer_valid),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word_data  (word_data)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        word_cnt_d   = word_cnt_q;
        xor_d        = xor_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr;
        imem_wdata_d = imem_wdata;
        core_reset_d = core_reset;
        done_d       = done;
        error_d      = error;
        packer_clear = 1'b0;

        case (state_q)
            LEN_LO: begin
                if (accept) begin
                    count_d = header;
                    xor_d   = xor_fold(xor_q, in_data);
                    state_d = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    count_d = header;
                    xor_d   = xor_fold(xor_q, in_data);
                    if (header == '0) begin
                        state_d = CHECK;
                    end else if ({1'b0, header} > MAX_COUNT) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    xor_d = xor_fold(xor_q, in_data);
                    if (word_valid) begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_cnt_q[ADDR_WIDTH-1:0];
                        imem_wdata_d = word_data;
                        word_cnt_d   = word_cnt_q + 1'b1;
                        if ((CW + 1)'(word_cnt_d) == {1'b0, count_q}) begin
                            state_d = CHECK;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    if (in_data == xor_q) begin
                        state_d      = RUN;
                        core_reset_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (reload) begin
                    state_d      = LEN_LO;
                    core_reset_d = 1'b1;
                    done_d       = 1'b0;
                    count_d      = '0;
                    word_cnt_d   = '0;
                    xor_d        = '0;
                    packer_clear = 1'b1;
                end
            end
            ERROR: begin
                core_reset_d = 1'b1;
                error_d      = 1'b1;
            end
            default: begin
                state_d = ERROR;
                error_d = 1'b1;
            end
        endcase

        in_ready_d = (state_d != RUN) && (state_d != ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= LEN_LO;
            count_q    <= '0;
            word_cnt_q <= '0;
            xor_q      <= '0;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            xor_q      <= xor_d;
            in_ready   <= in_ready_d;
            imem_we    <= imem_we_d;
            imem_addr  <= imem_addr_d;
            imem_wdata <= imem_wdata_d;
            core_reset <= core_reset_d;
            done       <= done_d;
            error      <= error_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// ----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench: expected instruction-memory writes are queued as frames are
// sent; a monitor pops and compares on every imem_we cycle. Status outputs are
// checked directly after each frame.
// ----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          reload = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_reset;
    logic          done;
    logic          error;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t sb[$];
    int  n_cmp  = 0;
    int  n_fail = 0;
    logic prev_we = 1'b0;

    logic [7:0] good_frame [11] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                    8'h13, 8'h81, 8'h10, 8'h00, 8'h43};

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard and
    // last exactly one cycle.
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            check("we_pulse_width", 32'(prev_we), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
        prev_we = reset ? 1'b0 : imem_we;
    end

    // Called at a negedge; presents one byte for exactly one cycle.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_good(input int max_gap);
        for (int i = 0; i < 11; i++) send_byte(good_frame[i], $urandom_range(0, max_gap));
    endtask

    task automatic expect_good_writes();
        sb.push_back('{addr: 8'd0, data: 32'h0050_0093});
        sb.push_back('{addr: 8'd1, data: 32'h0010_8113});
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic crst,
                                input logic dn, input logic err);
        check({tag, "_in_ready"},   32'(in_ready),   32'(rdy));
        check({tag, "_core_reset"}, 32'(core_reset), 32'(crst));
        check({tag, "_done"},       32'(done),       32'(dn));
        check({tag, "_error"},      32'(error),      32'(err));
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_status("reset", 1'b1, 1'b1, 1'b0, 1'b0);
        check("reset_we",    32'(imem_we),    32'd0);
        check("reset_addr",  32'(imem_addr),  32'd0);
        check("reset_wdata", imem_wdata,      32'd0);

        // Good load, back-to-back bytes
        expect_good_writes();
        send_good(0);
        check_status("good", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("good_sb_empty", 32'(sb.size()), 32'd0);

        // Reload from RUN, then a zero-length frame
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_status("reload", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("zero_len", 1'b0, 1'b0, 1'b1, 1'b0);

        // Bad checksum: writes still happen, then ERROR; later bytes ignored
        do_reset();
        expect_good_writes();
        for (int i = 0; i < 10; i++) send_byte(good_frame[i], 0);
        send_byte(8'h44, 0);
        check_status("bad_csum", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) send_byte(good_frame[i], 0);
        check_status("bad_csum_after", 1'b0, 1'b1, 1'b0, 1'b1);
        check("bad_csum_sb_empty", 32'(sb.size()), 32'd0);

        // Oversize count 257
        do_reset();
        send_byte(8'h01, 0);
        check_status("oversize_lo", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h01, 0);
        check_status("oversize", 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 2; i < 10; i++) send_byte(good_frame[i], 0);
        check_status("oversize_after", 1'b0, 1'b1, 1'b0, 1'b1);

        // Gapped in_valid
        do_reset();
        expect_good_writes();
        send_good(3);
        check_status("gapped", 1'b0, 1'b0, 1'b1, 1'b0);
        check("gapped_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-LOAD after 5 payload bytes (first word already written)
        do_reset();
        sb.push_back('{addr: 8'd0, data: 32'h0050_0093});
        for (int i = 0; i < 7; i++) send_byte(good_frame[i], 0);
        check("midload_sb_empty", 32'(sb.size()), 32'd0);
        do_reset();
        check_status("midload_reset", 1'b1, 1'b1, 1'b0, 1'b0);
        expect_good_writes();
        send_good(0);
        check_status("midload_good", 1'b0, 1'b0, 1'b1, 1'b0);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_status("midload_reload", 1'b1, 1'b1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle RISC-V core. It receives a byte stream (length header, little-endian instruction words, XOR checksum) over a valid/ready handshake and writes each assembled word into instruction memory through its write port. It holds the core in reset while loading and releases it only after a good checksum. It is the writer side of the instruction memory that the core's fetch path reads.

## Interface
Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; dominates all other inputs.
- in_valid  in  1  byte available on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on an edge where in_valid && in_ready.
- reload  in  1  sampled only in RUN; restarts loading.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_WIDTH  word address for the write.
- imem_wdata  out  32  instruction word.
- core_reset  out  1  drives the core's reset; high except in RUN.
- done  out  1  program loaded and core running.
- error  out  1  load failed; sticky until reset.

## Operation
- States: LEN_LO, LEN_HI, LOAD, CHECK, RUN, ERROR. Reset enters LEN_LO.
- Frame format: count[7:0], count[15:8], then count×4 payload bytes, then 1 checksum byte. The checksum byte equals the XOR of all preceding frame bytes, including both length bytes.
- LEN_LO → LEN_HI on accept. LEN_HI → on accept:
  - LOAD if 0 < count ≤ 2**ADDR_WIDTH.
  - CHECK if count == 0.
  - ERROR if count > 2**ADDR_WIDTH.
- LOAD: bytes are packed little-endian, so the first byte goes to wdata[7:0]. The 4th byte of each word triggers the write to word index 0, 1, 2, … After count words are written, the state moves to CHECK.
- CHECK: accept one byte.
  - Byte equals the running XOR → RUN.
  - Otherwise → ERROR.
- RUN: in_ready = 0. reload = 1 → LEN_LO, with core_reset reasserted and done cleared.
- ERROR: in_ready = 0, core_reset = 1, error = 1. Exit only via reset.
- The running XOR and the word counter clear on entry to LEN_LO.
- There is no explicit imem clear. Words beyond count keep their old contents.

## Timing
- All outputs are registered.
- Reset values:
  - in_ready = 1, core_reset = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, done = 0, error = 0.
  - Internal state: LEN_LO, XOR = 0, counters = 0.
- in_ready is 1 in LEN_LO, LEN_HI, LOAD and CHECK; it is 0 in RUN and ERROR. The loader itself never stalls the stream.
- Write strobe: at the edge accepting a word's 4th byte, imem_we, imem_addr and imem_wdata are loaded. imem_we is therefore high for exactly the following cycle and drops on the next edge. Back-to-back words produce a write every 4 accepted bytes.
- At the edge accepting a good checksum: core_reset ← 0 and done ← 1, both visible the next cycle.
- At the edge accepting a bad checksum or an oversize count: error ← 1; core_reset stays 1.
- reload in RUN: on the next edge core_reset ← 1 and done ← 0.
- Mid-frame reset: asynchronous return to the reset values. The partially loaded image is discarded logically; a new frame must start from the length bytes.
- imem_addr wraps are impossible because count is bounded by 2**ADDR_WIDTH.

## Structure
- Shared package `imem_loader_pkg` holds:
  - the state enum;
  - LEN_BYTES = 2 and WORD_BYTES = 4;
  - the checksum function (8-bit XOR fold).
- One sub-module, `byte_packer`, is natural: it shifts 4 bytes into a 32-bit word, has a 2-bit byte counter, and pulses word_valid.
- The FSM, word counter, XOR accumulator and output registers live in the top.

## Test plan
- Good load: stream 02 00 93 00 50 00 13 81 10 00 43.
  - Expect writes addr0 = 0x00500093 and addr1 = 0x00108113, each with a 1-cycle imem_we.
  - Then core_reset = 0 and done = 1.
- Bad checksum: same frame with last byte 44 → no RUN; error = 1, core_reset = 1, in_ready = 0. All further bytes are ignored.
- Zero-length frame: 00 00 00 → RUN with no imem_we pulses.
- Oversize count: with ADDR_WIDTH = 8, send 01 01 (count 257) → ERROR after the second byte, with no writes.
- Gapped in_valid: insert random idle cycles between bytes of the good frame. Write values and addresses must be identical to the good-load case.
- Reset mid-LOAD: assert reset after 5 payload bytes, then send the good frame.
  - Only the new frame's writes may occur, and done asserts.
  - reload in RUN then reasserts core_reset the next cycle.
